// File: rtl/lflaf_pkg.sv
// lflaf_pkg
//   Shared constants for the linear-to-log2 encoder.
//   Q-format constants:
//     FRAC_BITS      fractional bits of the Q4.12 log output
//     INT_OFFSET     MSB index of a full-scale Q1.15 magnitude (log2 of 2^15)
//     LUT_INDEX_BITS table index bits taken from the top of the fraction
//     INTERP_BITS    fraction bits below the index, used for interpolation
//   LOG2_LUT[j] = round(4096 * log2(1 + j/64)), j = 0..64.
package lflaf_pkg;

    localparam int FRAC_BITS      = 12;
    localparam int INT_OFFSET     = 15;
    localparam int LUT_INDEX_BITS = 6;
    localparam int INTERP_BITS    = 8;
    localparam int F_BITS         = LUT_INDEX_BITS + INTERP_BITS;
    localparam int LUT_ENTRIES    = (1 << LUT_INDEX_BITS) + 1;

    // One extra bit so the closing entry (exactly 1.0 = 4096) fits.
    typedef logic [FRAC_BITS:0] lut_entry_t;

    localparam lut_entry_t LOG2_LUT [LUT_ENTRIES] = '{
        13'd0,    13'd92,   13'd182,  13'd271,  13'd358,  13'd445,  13'd530,  13'd613,
        13'd696,  13'd778,  13'd858,  13'd937,  13'd1016, 13'd1093, 13'd1169, 13'd1244,
        13'd1319, 13'd1392, 13'd1465, 13'd1536, 13'd1607, 13'd1677, 13'd1746, 13'd1814,
        13'd1882, 13'd1949, 13'd2015, 13'd2080, 13'd2145, 13'd2208, 13'd2272, 13'd2334,
        13'd2396, 13'd2457, 13'd2518, 13'd2578, 13'd2637, 13'd2696, 13'd2754, 13'd2812,
        13'd2869, 13'd2926, 13'd2982, 13'd3037, 13'd3092, 13'd3146, 13'd3200, 13'd3254,
        13'd3307, 13'd3359, 13'd3412, 13'd3463, 13'd3514, 13'd3565, 13'd3615, 13'd3665,
        13'd3715, 13'd3764, 13'd3812, 13'd3861, 13'd3908, 13'd3956, 13'd4003, 13'd4050,
        13'd4096
    };

endpackage

// File: rtl/log2_frac_lut.sv
// log2_frac_lut
//   Combinational log2 mantissa: for a normalised fraction f (value f/2^14,
//   implied leading one above it) returns frac = 4096*log2(1 + f/2^14)
//   using a 65-entry table with linear interpolation between entries.
// Ports:
//   f     in  [13:0]  fraction field below the leading one
//   frac  out [11:0]  log2 fractional part, Q0.12
module log2_frac_lut
    import lflaf_pkg::*;
(
    input  logic [F_BITS-1:0]    f,
    output logic [FRAC_BITS-1:0] frac
);

    localparam int IDX_W  = LUT_INDEX_BITS + 1;
    localparam int PROD_W = FRAC_BITS + INTERP_BITS + 1;

    logic [IDX_W-1:0]  idx_lo;
    logic [IDX_W-1:0]  idx_hi;
    lut_entry_t        lo;
    lut_entry_t        hi;
    lut_entry_t        step;
    logic [PROD_W-1:0] prod;

    assign idx_lo = {1'b0, f[F_BITS-1 -: LUT_INDEX_BITS]};
    assign idx_hi = idx_lo + IDX_W'(1);
    assign lo     = LOG2_LUT[idx_lo];
    assign hi     = LOG2_LUT[idx_hi];
    // Table is monotonic, so the step is always non-negative.
    assign step   = hi - lo;
    assign prod   = PROD_W'(step) * PROD_W'(f[INTERP_BITS-1:0]);

    // Largest result is 4050 + 45 at the top index, so 12 bits always hold it.
    assign frac = FRAC_BITS'(lo + (FRAC_BITS + 1)'(prod >> INTERP_BITS));

endmodule

// File: rtl/lin_to_log_encoder.sv
// lin_to_log_encoder
//   Three-stage valid/ready pipeline converting a signed Q1.15 sample into
//   sign + log2 magnitude in Q4.12.
//     S1: saturating absolute value, sign capture, zero detect
//     S2: leading-one priority encoder and normalising left shift
//     S3: table/interpolation lookup and output register
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   in_vld     in   data_in valid
//   in_rdy     out  encoder accepts data_in
//   data_in    in   [WIDTH-1:0] signed linear sample
//   out_vld    out  output triple valid
//   out_rdy    in   downstream accepts output triple
//   log_out    out  [LOG_WIDTH-1:0] signed log2(|data_in|/2^15), Q4.12
//   log_sign   out  sign of data_in
//   log_valid  out  0 when the sample was zero (log undefined)
module lin_to_log_encoder
    import lflaf_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int LOG_WIDTH = 17
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic [WIDTH-1:0]     data_in,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [LOG_WIDTH-1:0] log_out,
    output logic                 log_sign,
    output logic                 log_valid
);

    localparam int MAG_W = WIDTH - 1;
    localparam int K_W   = $clog2(MAG_W);
    localparam int INT_W = LOG_WIDTH - FRAC_BITS;

    logic v1, v2, v3;
    logic adv1, adv2, adv3;

    logic             sign1, zero1;
    logic [MAG_W-1:0] mag1;
    logic [MAG_W-1:0] mag_in;

    logic              sign2, zero2;
    logic [K_W-1:0]    k2;
    logic [F_BITS-1:0] f2;
    logic [K_W-1:0]    lead_k;
    logic [K_W-1:0]    shamt;
    logic [F_BITS-1:0] f_next;

    logic [FRAC_BITS-1:0] frac;
    logic [INT_W-1:0]     int_part;
    logic [LOG_WIDTH-1:0] log_next;

    // A stage moves when it is empty or the stage after it moves.
    assign adv3    = out_rdy | ~v3;
    assign adv2    = adv3 | ~v2;
    assign adv1    = adv2 | ~v1;
    assign in_rdy  = adv1;
    assign out_vld = v3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (adv1) v1 <= in_vld;
            if (adv2) v2 <= v1;
            if (adv3) v3 <= v2;
        end
    end

    // The most negative input has no positive twin; clamp to full scale.
    always_comb begin
        mag_in = MAG_W'(data_in);
        if (data_in[WIDTH-1]) begin
            if (data_in[WIDTH-2:0] == '0)
                mag_in = '1;
            else
                mag_in = MAG_W'(-data_in);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sign1 <= 1'b0;
            zero1 <= 1'b0;
            mag1  <= '0;
        end else if (adv1) begin
            sign1 <= data_in[WIDTH-1];
            zero1 <= (data_in == '0);
            mag1  <= mag_in;
        end
    end

    // Priority encoder: the highest set bit wins because it is assigned last.
    always_comb begin
        lead_k = '0;
        for (int i = 0; i < MAG_W; i++) begin
            if (mag1[i]) lead_k = K_W'(i);
        end
    end

    // Shift the leading one up to the MSB, keep the bits directly below it.
    assign shamt  = K_W'(MAG_W - 1) - lead_k;
    assign f_next = F_BITS'((mag1 << shamt) >> (MAG_W - 1 - F_BITS));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sign2 <= 1'b0;
            zero2 <= 1'b0;
            k2    <= '0;
            f2    <= '0;
        end else if (adv2) begin
            sign2 <= sign1;
            zero2 <= zero1;
            k2    <= lead_k;
            f2    <= f_next;
        end
    end

    log2_frac_lut u_lut (
        .f    (f2),
        .frac (frac)
    );

    // frac < 4096, so (k-15)*4096 + frac is just the integer part
    // concatenated above the fraction, in two's complement.
    assign int_part = INT_W'(k2) - INT_W'(INT_OFFSET);
    assign log_next = zero2 ? '0 : {int_part, frac};

    // Load only when a real sample arrives so idle outputs stay quiet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            log_out   <= '0;
            log_sign  <= 1'b0;
            log_valid <= 1'b0;
        end else if (adv3 && v2) begin
            log_out   <= log_next;
            log_sign  <= sign2;
            log_valid <= ~zero2;
        end
    end

endmodule

// File: tb/tb_lin_to_log_encoder.sv
module tb_lin_to_log_encoder;

    localparam int W  = 16;
    localparam int LW = 17;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_vld;
    logic          in_rdy;
    logic [W-1:0]  data_in;
    logic          out_vld;
    logic          out_rdy;
    logic [LW-1:0] log_out;
    logic          log_sign;
    logic          log_valid;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] d;
        bit          exact;
        int          xlog;
    } exp_t;

    exp_t expq[$];
    bit   cur_exact;
    int   cur_xlog;

    lin_to_log_encoder #(.WIDTH(W), .LOG_WIDTH(LW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .data_in   (data_in),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .log_out   (log_out),
        .log_sign  (log_sign),
        .log_valid (log_valid)
    );

    always #5 clk = ~clk;

    // Real-valued reference: log2(|x|/2^15) in units of 2^-12.
    function automatic real ref_log(input logic [15:0] d);
        int v, m;
        v = int'($signed(d));
        m = (v < 0) ? -v : v;
        if (m > 32767) m = 32767;
        if (m == 0) return 0.0;
        return $ln(real'(m)) / $ln(2.0) * 4096.0 - 61440.0;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    // Per-cycle checker, sampled at the falling edge.
    bit          prev_hold;
    logic [LW-1:0] prev_log;
    logic        prev_sign, prev_lv;
    bit [2:0]    hist;
    int          run;

    always @(negedge clk) begin
        if (reset) begin
            prev_hold = 0;
            hist      = '0;
            run       = 0;
        end else begin
            chk("in_rdy_vs_occupancy", int'(in_rdy), int'(!(expq.size() == 3 && !out_rdy)));
            if (expq.size() == 0) chk("out_vld_when_empty", int'(out_vld), 0);
            if (run >= 3) chk("one_per_cycle_latency", int'(out_vld), int'(hist[2]));
            if (prev_hold) begin
                chk("hold_out_vld", int'(out_vld), 1);
                chk("hold_log_out", int'($signed(log_out)), int'($signed(prev_log)));
                chk("hold_log_sign", int'(log_sign), int'(prev_sign));
                chk("hold_log_valid", int'(log_valid), int'(prev_lv));
            end
            if (out_vld && out_rdy) begin
                if (expq.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    int   sl;
                    real  r, dv;
                    e  = expq.pop_front();
                    sl = int'($signed(log_out));
                    chk("log_sign", int'(log_sign), int'(e.d[15]));
                    chk("log_valid", int'(log_valid), int'(e.d != 16'd0));
                    if (e.d == 16'd0) begin
                        chk("log_out_zero", sl, 0);
                    end else if (e.exact) begin
                        chk("log_out_exact", sl, e.xlog);
                    end else begin
                        r  = ref_log(e.d);
                        dv = real'(sl) - r;
                        total++;
                        if (dv > 2.0 || dv < -2.0) begin
                            bad++;
                            $display("FAIL log_out_model data=%0d actual=%0d required=%f", $signed(e.d), sl, r);
                        end
                    end
                end
            end
            if (in_vld && in_rdy) begin
                exp_t n;
                n.d     = data_in;
                n.exact = cur_exact;
                n.xlog  = cur_xlog;
                expq.push_back(n);
            end
            prev_hold = out_vld && !out_rdy;
            prev_log  = log_out;
            prev_sign = log_sign;
            prev_lv   = log_valid;
            hist      = {hist[1:0], in_vld && in_rdy};
            run       = out_rdy ? run + 1 : 0;
        end
    end

    // Present one sample and hold it until accepted; returns at edge + 1.
    task automatic send(input logic [15:0] d, input bit ex, input int xl);
        bit a;
        bit done;
        in_vld    = 1'b1;
        data_in   = d;
        cur_exact = ex;
        cur_xlog  = xl;
        done      = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            a = in_rdy;
            @(posedge clk);
            #1;
            if (a) done = 1;
        end
        if (!done) chk("send_timeout", 0, 1);
        in_vld = 1'b0;
    endtask

    task automatic drain();
        out_rdy = 1'b1;
        in_vld  = 1'b0;
        for (int n = 0; n < 40 && expq.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        chk("drain_empty", expq.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        reset     = 1'b1;
        in_vld    = 1'b0;
        out_rdy   = 1'b1;
        data_in   = '0;
        cur_exact = 0;
        cur_xlog  = 0;

        chk("model_pin_16384", int'(ref_log(16'd16384)), -4096);
        chk("model_pin_24576", int'(ref_log(16'd24576)), -1700);
        chk("model_pin_1", int'(ref_log(16'd1)), -61440);

        #12;
        chk("rst_out_vld", int'(out_vld), 0);
        chk("rst_log_out", int'(log_out), 0);
        chk("rst_log_sign", int'(log_sign), 0);
        chk("rst_log_valid", int'(log_valid), 0);
        chk("rst_in_rdy", int'(in_rdy), 1);
        @(posedge clk);
        #2 reset = 1'b0;

        // Latency into an empty pipe.
        send(16'd16384, 1, -4096);
        chk("lat_after_accept", int'(out_vld), 0);
        @(posedge clk); #1;
        chk("lat_plus1", int'(out_vld), 0);
        @(posedge clk); #1;
        chk("lat_plus2", int'(out_vld), 1);
        chk("lat_log_out", int'($signed(log_out)), -4096);
        drain();

        // Directed boundary values, back to back.
        send(16'hC000, 1, -4096);   // -16384
        send(16'd24576, 1, -1700);
        send(16'd1, 1, -61440);
        send(16'd0, 1, 0);
        send(16'h8000, 1, -1);      // -32768 saturates to 32767
        send(16'd32767, 1, -1);
        send(16'hFFFF, 1, -61440);  // -1
        send(16'd3, 1, -54948);     // -14*4096 + L[32]
        drain();

        // 100-sample stream with no backpressure.
        for (int i = 0; i < 100; i++) send(16'($urandom), 0, 0);
        drain();

        // Fill the pipe, stall 5 cycles, then release.
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) send(16'($urandom), 0, 0);
        in_vld    = 1'b1;
        data_in   = 16'($urandom);
        cur_exact = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_in_rdy", int'(in_rdy), 0);
            chk("stall_out_vld", int'(out_vld), 1);
        end
        out_rdy = 1'b1;
        send(data_in, 0, 0);
        for (int i = 0; i < 4; i++) send(16'($urandom), 0, 0);
        drain();

        // Random valid/ready traffic.
        in_vld = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            acc = in_vld && in_rdy;
            @(posedge clk); #1;
            if (acc || !in_vld) begin
                if ($urandom_range(9) < 7) begin
                    in_vld    = 1'b1;
                    data_in   = 16'($urandom);
                    cur_exact = 0;
                end else begin
                    in_vld = 1'b0;
                end
            end
            out_rdy = ($urandom_range(9) < 6);
        end
        drain();

        // Reset with three samples in flight.
        out_rdy = 1'b0;
        send(16'hA000, 0, 0);       // -24576
        send(16'd777, 0, 0);
        send(16'd12345, 0, 0);
        chk("pre_rst_out_vld", int'(out_vld), 1);
        #2 reset = 1'b1;
        expq.delete();
        #1;
        chk("mid_rst_out_vld", int'(out_vld), 0);
        chk("mid_rst_log_out", int'(log_out), 0);
        chk("mid_rst_log_sign", int'(log_sign), 0);
        chk("mid_rst_log_valid", int'(log_valid), 0);
        chk("mid_rst_in_rdy", int'(in_rdy), 1);
        @(posedge clk);
        #2 reset = 1'b0;
        out_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("no_stale_output", int'(out_vld), 0);
        end

        // Still functional after reset.
        send(16'd24576, 1, -1700);
        send(16'hC000, 1, -4096);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lin_to_log_encoder.md
LIN_TO_LOG_ENCODER -- requirements
Module: lin_to_log_encoder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: signed linear input width, Q1.15 (value = data_in/2^15).
REQ-002 SHALL have parameter LOG_WIDTH, default 17: signed log2 output width, Q4.12.
REQ-003 SHALL have port clk  input  1: single clock, rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port in_vld  input  1: data_in is valid this cycle.
REQ-006 SHALL have port in_rdy  output  1: encoder accepts data_in this cycle.
REQ-007 SHALL have port data_in  input  WIDTH: signed linear sample.
REQ-008 SHALL have port out_vld  output  1: output triple is valid.
REQ-009 SHALL have port out_rdy  input  1: downstream accepts the output triple.
REQ-010 SHALL have port log_out  output  LOG_WIDTH: signed log2(|data_in|/2^15), Q4.12.
REQ-011 SHALL have port log_sign  output  1: sign of data_in (1 = negative).
REQ-012 SHALL have port log_valid  output  1: 0 when |data_in| = 0 (log undefined); it feeds the log-domain multiplier valid input.

Function
REQ-013 SHALL be a 3-stage valid/ready pipeline: S1 abs/sign/zero-detect, S2 leading-one detect and normalise, S3 LUT lookup, interpolation, output register.
REQ-014 SHALL transfer on in_vld & in_rdy at input and on out_vld & out_rdy at output.
REQ-015 SHALL advance a stage when that stage is empty or the next stage advances, giving full throughput (1 sample/cycle) with no bubbles when out_rdy = 1.
REQ-016 SHALL have a latency of 3 cycles from input transfer to out_vld with no backpressure.
REQ-017 SHALL drive in_rdy = 0 only when all three stages hold data and out_rdy = 0.
REQ-018 SHALL hold log_out, log_sign and log_valid stable while out_vld = 1 and out_rdy = 0.
REQ-019 SHALL compute magnitude mag = |data_in|, saturating data_in = -2^(WIDTH-1) to 2^(WIDTH-1)-1.
REQ-020 SHALL produce log_sign = data_in[WIDTH-1] for every sample, including zero.
REQ-021 SHALL, for mag = 0, output log_valid = 0 and log_out = 0.
REQ-022 SHALL, for mag != 0, compute k = MSB index of mag (0..14) and integer part k-15.
REQ-023 SHALL form fraction f = 14-bit field below the leading one after left-shifting mag by 14-k.
REQ-024 SHALL compute frac = L[i] + (((L[i+1]-L[i]) * f[7:0]) >> 8), with i = f[13:8] and L[j] = round(4096*log2(1+j/64)) for j = 0..64 (L[64] = 4096); the >> 8 is a truncating shift.
REQ-025 SHALL output log_out = (k-15)*4096 + frac, sign-extended to LOG_WIDTH; the result range is [-61440, -1] and it never overflows.

Reset
REQ-026 SHALL, while reset is asserted, asynchronously clear all stage valid flags, out_vld, log_out, log_sign and log_valid to 0.
REQ-027 SHALL drive in_rdy = 1 out of reset.
REQ-028 SHALL discard in-flight samples on reset mid-operation and produce no output for them after release.

Structure
REQ-029 SHALL place the Q-format constants (FRAC_BITS = 12, INT_OFFSET = 15, LUT_INDEX_BITS = 6) and the 65-entry L table constant in the shared lflaf_pkg package.
REQ-030 SHALL implement the table with interpolation as the combinational sub-module log2_frac_lut (input f[13:0], output frac[11:0]).
REQ-031 SHALL implement the leading-one detector inline as a priority encoder.

Verification
REQ-032 SHALL cover: data_in = 16384 -> log_out = -4096, log_sign = 0, log_valid = 1, out_vld exactly 3 cycles after accept.
REQ-033 SHALL cover: data_in = -16384 -> log_out = -4096, log_sign = 1; data_in = 24576 -> log_out = -1700; data_in = 1 -> log_out = -61440.
REQ-034 SHALL cover: data_in = 0 -> log_valid = 0, log_out = 0; data_in = -32768 -> log_out = -1, log_sign = 1.
REQ-035 SHALL cover: back-to-back stream of 100 random samples with out_rdy = 1 -> one output per cycle, in order, matching a real-valued log2 model within 2 LSB.
REQ-036 SHALL cover: out_rdy held 0 for 5 cycles with a full pipe -> in_rdy = 0 and outputs stable; then out_rdy = 1 -> no sample lost or duplicated.
REQ-037 SHALL cover: reset asserted with 3 samples in flight -> out_vld = 0 immediately and no stale output after release.
